// File: rtl/fbuf_arbiter.sv
// -----------------------------------------------------------------------------
// fbuf_arbiter
//
// Shares one single-port 512x16 framebuffer RAM between three masters:
//   - display scanout (word fetches, never stalled)
//   - hardware clear engine (fills the RAM with CLEAR_VALUE during blanking)
//   - Chip-8 CPU (req/ack reads and writes, lowest priority)
//
// Per-cycle fixed priority: display > clear > CPU. Exactly one owner drives
// the RAM port in any cycle.
//
// Build option:
//   FBUF_CLEAR_EN  defined   -> clear engine present.
//                  undefined -> clr_req is ignored, clr_busy/clr_done tie to 0,
//                               priority reduces to display > CPU.
//
// Ports:
//   clk, res                    clock; asynchronous active-low reset
//   beam_outside                1 = beam outside the playfield (clear may run)
//   disp_req/disp_addr          display fetch strobe and address
//   disp_data/disp_valid        fetched word, one cycle after disp_req
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request, held until cpu_ack
//   cpu_ack                     access performed this cycle (combinational)
//   cpu_rdata/cpu_rvalid        CPU read data, the cycle after a read ack
//   clr_req                     start-clear pulse
//   clr_busy/clr_done           clear running / one-cycle done pulse
//   ram_addr/ram_we/ram_wdata   RAM command port
//   ram_rdata                   RAM read data, 1-cycle latency
//
// Handshake: the CPU raises cpu_req with cpu_we/cpu_addr/cpu_wdata stable and
// holds them until it sees cpu_ack=1; the access happens in that ack cycle.
// A new request may be raised in the cycle after the ack. For reads,
// cpu_rvalid pulses exactly one cycle after the ack. The display side has no
// back-pressure: every disp_req cycle returns disp_valid one cycle later.
//
// All registered state lives in the packed struct `st` (read-owner pipe and,
// when built, the clear FSM state, counter and done flag) so checkers can
// bind to a single signal.
// -----------------------------------------------------------------------------
module fbuf_arbiter #(
  parameter int                ADDR_W      = 9,
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              res,
  input  logic              beam_outside,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Owner of the read issued in the previous cycle; decodes the valids.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

`ifdef FBUF_CLEAR_EN
  typedef enum logic {
    C_IDLE = 1'b0,
    C_RUN  = 1'b1
  } clr_state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;
`endif

  typedef struct packed {
    owner_t            rd_owner;
`ifdef FBUF_CLEAR_EN
    clr_state_t        clr_state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_done;
`endif
  } state_t;

  state_t st;
  state_t st_d;

  logic grant_disp;
  logic grant_clr;
  logic grant_cpu;

  // ---------------------------------------------------------------------------
  // Grants. Gated with res so that every output reads 0 while reset is held,
  // even though the inputs may be toggling.
  // ---------------------------------------------------------------------------
`ifdef FBUF_CLEAR_EN
  assign clr_busy = (st.clr_state == C_RUN);
  assign clr_done = st.clr_done;
  // Clear only steals cycles the display does not want, and only in blanking.
  assign grant_clr = res && clr_busy && beam_outside && !disp_req;
`else
  assign clr_busy  = 1'b0;
  assign clr_done  = 1'b0;
  assign grant_clr = 1'b0;

  // The clear inputs and fill value have no function in this build.
  logic                    clr_inputs_unused;
  logic [DATA_W-1:0]       clear_value_unused;
  assign clr_inputs_unused  = clr_req ^ beam_outside;
  assign clear_value_unused = CLEAR_VALUE;
`endif

  assign grant_disp = res && disp_req;
  // clr_busy (not grant_clr) blocks the CPU: it waits for the whole clear.
  assign grant_cpu  = res && cpu_req && !disp_req && !clr_busy;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      st <= '0;
    end else begin
      st <= st_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    st_d = st;

    if (grant_disp) begin
      st_d.rd_owner = OWN_DISP;
    end else if (grant_cpu && !cpu_we) begin
      st_d.rd_owner = OWN_CPU;
    end else begin
      st_d.rd_owner = OWN_NONE;
    end

`ifdef FBUF_CLEAR_EN
    st_d.clr_done = 1'b0;
    case (st.clr_state)
      C_IDLE: begin
        if (clr_req) begin
          st_d.clr_state = C_RUN;
        end
      end
      C_RUN: begin
        // clr_req is not looked at here, so a request mid-clear is dropped.
        if (grant_clr) begin
          st_d.clr_cnt = st.clr_cnt + 1'b1;  // wraps to 0 after the last word
          if (st.clr_cnt == CNT_LAST) begin
            st_d.clr_state = C_IDLE;
            st_d.clr_done  = 1'b1;
          end
        end
      end
      default: begin
        st_d.clr_state = C_IDLE;
      end
    endcase
`endif
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;

    if (grant_disp) begin
      ram_addr = disp_addr;
    end else if (grant_clr) begin
`ifdef FBUF_CLEAR_EN
      ram_addr  = st.clr_cnt;
      ram_we    = 1'b1;
      ram_wdata = CLEAR_VALUE;
`endif
    end else if (grant_cpu) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      if (cpu_we) begin
        ram_wdata = cpu_wdata;
      end
    end
  end

  always_comb begin
    cpu_ack    = grant_cpu;
    disp_valid = (st.rd_owner == OWN_DISP);
    cpu_rvalid = (st.rd_owner == OWN_CPU);
    // Data buses are zero unless their valid is up, so idle outputs stay 0.
    disp_data  = disp_valid ? ram_rdata : '0;
    cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_fbuf_arbiter.sv
module tb_fbuf_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int NV     = 18;

  logic              clk = 1'b0;
  logic              res;
  logic              beam_outside;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- DUT
  fbuf_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .CLEAR_VALUE (16'h0000)
  ) dut (
    .clk          (clk),
    .res          (res),
    .beam_outside (beam_outside),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_data    (disp_data),
    .disp_valid   (disp_valid),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .cpu_rvalid   (cpu_rvalid),
    .clr_req      (clr_req),
    .clr_busy     (clr_busy),
    .clr_done     (clr_done),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  // ---------------------------------------------------------------- RAM model
  // Synchronous single-port RAM, read-before-write, 1-cycle read latency.
  logic              preload_en    = 1'b0;
  logic              preload_ident = 1'b0;
  logic [DATA_W-1:0] preload_val   = '0;
  logic [DATA_W-1:0] mem [0:511];

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < 512; i++) begin
        mem[i] <= preload_ident ? 16'(i) : preload_val;
      end
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic              dr;
    logic [ADDR_W-1:0] da;
    logic              cr;
    logic              cw;
    logic [ADDR_W-1:0] ca;
    logic [DATA_W-1:0] cd;
    logic              bo;
    logic              e_ack;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic              e_dv;
    logic [DATA_W-1:0] e_dd;
    logic              e_cv;
    logic [DATA_W-1:0] e_cd;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic dr, input logic [8:0] da, input logic cr, input logic cw,
    input logic [8:0] ca, input logic [15:0] cd, input logic bo,
    input logic ea, input logic ew, input logic [8:0] eaddr,
    input logic [15:0] ewd, input logic edv, input logic [15:0] edd,
    input logic ecv, input logic [15:0] ecd);
    vec_t v;
    v.dr = dr; v.da = da; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.bo = bo;
    v.e_ack = ea; v.e_we = ew; v.e_addr = eaddr; v.e_wdata = ewd;
    v.e_dv = edv; v.e_dd = edd; v.e_cv = ecv; v.e_cd = ecd;
    return v;
  endfunction

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic sb_disp(input string name);
    logic [DATA_W-1:0] e;
    if (disp_valid) begin
      if (exp_q.size() == 0) begin
        check({name, "_unexpected_valid"}, 64'(disp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check(name, 64'(disp_data), 64'(e));
      end
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({disp_data, disp_valid, cpu_ack, cpu_rdata, cpu_rvalid,
                clr_busy, clr_done, ram_addr, ram_we, ram_wdata});
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic idle_inputs();
    disp_req = 1'b0; disp_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; clr_req = 1'b0; beam_outside = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    disp_req = v.dr; disp_addr = v.da; cpu_req = v.cr; cpu_we = v.cw;
    cpu_addr = v.ca; cpu_wdata = v.cd; beam_outside = v.bo; clr_req = 1'b0;
  endtask

  task automatic preload(input logic ident, input logic [DATA_W-1:0] val);
    preload_ident = ident;
    preload_val   = val;
    preload_en    = 1'b1;
    next_cycle();
    preload_en    = 1'b0;
  endtask

`ifdef FBUF_CLEAR_EN
  // Runs a started clear until clr_done (bounded). c=0 is the first cycle in
  // which clr_busy is expected high. beam_outside is low during the pause.
  task automatic run_clear(input int p_start, input int p_len, input bit with_cpu,
                           output int done_cyc, output int n_wr, output int p_wr,
                           output int bad_wr, output int ack_cyc, output int ack_busy,
                           output logic busy0);
    logic [ADDR_W-1:0] exp_a;
    bit acked;
    exp_a = '0; acked = 1'b0; done_cyc = -1; n_wr = 0; p_wr = 0; bad_wr = 0;
    ack_cyc = -1; ack_busy = 0; busy0 = 1'b0;
    for (int c = 0; c < 1200 && done_cyc < 0; c++) begin
      beam_outside = (c >= p_start && c < p_start + p_len) ? 1'b0 : 1'b1;
      cpu_req  = with_cpu && (c >= 10) && !acked;
      cpu_we   = 1'b0;
      cpu_addr = 9'h007;
      @(negedge clk);
      if (c == 0) busy0 = clr_busy;
      if (cpu_ack) begin
        if (clr_busy) ack_busy++;
        if (ack_cyc < 0) ack_cyc = c;
        acked = 1'b1;
      end
      if (ram_we) begin
        if (ram_addr !== exp_a || ram_wdata !== 16'h0000) bad_wr++;
        exp_a = exp_a + 1'b1;
        n_wr++;
        if (c >= p_start && c < p_start + p_len) p_wr++;
      end
      if (clr_done) done_cyc = c;
      next_cycle();
    end
    cpu_req = 1'b0;
  endtask

  task automatic start_clear();
    beam_outside = 1'b1;
    clr_req = 1'b1;
    @(negedge clk);
    check("clr_busy_before_start", 64'(clr_busy), 64'd0);
    next_cycle();
    clr_req = 1'b0;
  endtask
`endif

  // ---------------------------------------------------------------- test
  initial begin
    int done_cyc, n_wr, p_wr, bad_wr, ack_cyc, ack_busy;
    logic busy0;

    vecs[0]  = mk(0, 9'h000, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 9'h000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vecs[1]  = mk(0, 9'h000, 1, 1, 9'h005, 16'hA5A5, 0,  1, 1, 9'h005, 16'hA5A5, 0, 16'h0000, 0, 16'h0000);
    vecs[2]  = mk(0, 9'h000, 1, 0, 9'h005, 16'h0000, 0,  1, 0, 9'h005, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vecs[3]  = mk(0, 9'h000, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 9'h000, 16'h0000, 0, 16'h0000, 1, 16'hA5A5);
    vecs[4]  = mk(1, 9'h010, 1, 0, 9'h020, 16'h0000, 0,  0, 0, 9'h010, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vecs[5]  = mk(0, 9'h000, 1, 0, 9'h020, 16'h0000, 0,  1, 0, 9'h020, 16'h0000, 1, 16'h0010, 0, 16'h0000);
    vecs[6]  = mk(0, 9'h000, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 9'h000, 16'h0000, 0, 16'h0000, 1, 16'h0020);
    vecs[7]  = mk(1, 9'h1FF, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 9'h1FF, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vecs[8]  = mk(1, 9'h0AA, 1, 1, 9'h0AA, 16'h1234, 0,  0, 0, 9'h0AA, 16'h0000, 1, 16'h01FF, 0, 16'h0000);
    vecs[9]  = mk(0, 9'h000, 1, 1, 9'h0AA, 16'h1234, 0,  1, 1, 9'h0AA, 16'h1234, 1, 16'h00AA, 0, 16'h0000);
    vecs[10] = mk(1, 9'h0AA, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 9'h0AA, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vecs[11] = mk(0, 9'h000, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 9'h000, 16'h0000, 1, 16'h1234, 0, 16'h0000);
    vecs[12] = mk(0, 9'h000, 1, 0, 9'h1FF, 16'h0000, 1,  1, 0, 9'h1FF, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vecs[13] = mk(1, 9'h000, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 9'h000, 16'h0000, 0, 16'h0000, 1, 16'h01FF);
    vecs[14] = mk(0, 9'h000, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 9'h000, 16'h0000, 1, 16'h0000, 0, 16'h0000);
    vecs[15] = mk(1, 9'h003, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 9'h003, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vecs[16] = mk(1, 9'h004, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 9'h004, 16'h0000, 1, 16'h0003, 0, 16'h0000);
    vecs[17] = mk(0, 9'h000, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 9'h000, 16'h0000, 1, 16'h0004, 0, 16'h0000);

    // Reset held with random inputs: every output must be 0.
    res = 1'b0;
    idle_inputs();
    #1;
    preload(1'b1, 16'h0000);  // mem[i] = i
    for (int i = 0; i < 8; i++) begin
      disp_req     = 1'($urandom_range(0, 1));
      disp_addr    = 9'($urandom_range(0, 511));
      cpu_req      = 1'($urandom_range(0, 1));
      cpu_we       = 1'($urandom_range(0, 1));
      cpu_addr     = 9'($urandom_range(0, 511));
      cpu_wdata    = 16'($urandom_range(0, 65535));
      clr_req      = 1'($urandom_range(0, 1));
      beam_outside = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("reset_outs_%0d", i), all_outs(), 64'd0);
      next_cycle();
    end
    idle_inputs();
    res = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_outs_%0d", i), all_outs(), 64'd0);
      next_cycle();
    end

    // Table-driven single-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d_ack", i),    64'(cpu_ack),    64'(vecs[i].e_ack));
      check($sformatf("v%0d_we", i),     64'(ram_we),     64'(vecs[i].e_we));
      check($sformatf("v%0d_addr", i),   64'(ram_addr),   64'(vecs[i].e_addr));
      check($sformatf("v%0d_wdata", i),  64'(ram_wdata),  64'(vecs[i].e_wdata));
      check($sformatf("v%0d_dvalid", i), 64'(disp_valid), 64'(vecs[i].e_dv));
      check($sformatf("v%0d_ddata", i),  64'(disp_data),  64'(vecs[i].e_dd));
      check($sformatf("v%0d_cvalid", i), 64'(cpu_rvalid), 64'(vecs[i].e_cv));
      check($sformatf("v%0d_cdata", i),  64'(cpu_rdata),  64'(vecs[i].e_cd));
      check($sformatf("v%0d_clr", i),    64'({clr_busy, clr_done}), 64'd0);
      next_cycle();
    end
    idle_inputs();

    // Display every cycle for 8 cycles while the CPU holds a read request.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h030;
    for (int i = 0; i < 8; i++) begin
      disp_req  = 1'b1;
      disp_addr = 9'(9'h040 + i);
      exp_q.push_back(16'(16'h0040 + i));
      @(negedge clk);
      check($sformatf("starve_ack_%0d", i), 64'(cpu_ack), 64'd0);
      check($sformatf("starve_dvalid_%0d", i), 64'(disp_valid), 64'(i > 0));
      sb_disp($sformatf("starve_ddata_%0d", i));
      next_cycle();
    end
    disp_req = 1'b0;
    @(negedge clk);
    check("starve_free_ack", 64'(cpu_ack), 64'd1);
    check("starve_free_addr", 64'(ram_addr), 64'h030);
    sb_disp("starve_last_ddata");
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    check("starve_rvalid", 64'(cpu_rvalid), 64'd1);
    check("starve_rdata", 64'(cpu_rdata), 64'h0030);
    check("starve_dvalid_after", 64'(disp_valid), 64'd0);
    check("starve_queue_empty", 64'(exp_q.size()), 64'd0);
    next_cycle();

`ifdef FBUF_CLEAR_EN
    // Full clear with no display traffic.
    preload(1'b0, 16'hFFFF);
    start_clear();
    run_clear(0, 0, 1'b0, done_cyc, n_wr, p_wr, bad_wr, ack_cyc, ack_busy, busy0);
    check("clr_busy_first", 64'(busy0), 64'd1);
    check("clr_done_cycle", 64'(done_cyc), 64'd512);
    check("clr_write_count", 64'(n_wr), 64'd512);
    check("clr_write_addr_data", 64'(bad_wr), 64'd0);
    @(negedge clk);
    check("clr_after_done", 64'({clr_busy, clr_done}), 64'd0);
    next_cycle();
    // Read every word back through the display port.
    for (int a = 0; a < 512; a++) begin
      disp_req  = 1'b1;
      disp_addr = 9'(a);
      exp_q.push_back(16'h0000);
      @(negedge clk);
      sb_disp($sformatf("clr_readback_%0d", a - 1));
      next_cycle();
    end
    disp_req = 1'b0;
    @(negedge clk);
    sb_disp("clr_readback_511");
    check("clr_readback_queue_empty", 64'(exp_q.size()), 64'd0);
    next_cycle();

    // Clear paused for 100 cycles, CPU held off until clr_done.
    preload(1'b0, 16'hFFFF);
    start_clear();
    run_clear(50, 100, 1'b1, done_cyc, n_wr, p_wr, bad_wr, ack_cyc, ack_busy, busy0);
    check("pclr_busy_first", 64'(busy0), 64'd1);
    check("pclr_done_cycle", 64'(done_cyc), 64'd612);
    check("pclr_write_count", 64'(n_wr), 64'd512);
    check("pclr_pause_writes", 64'(p_wr), 64'd0);
    check("pclr_write_addr_data", 64'(bad_wr), 64'd0);
    check("pclr_cpu_ack_cycle", 64'(ack_cyc), 64'd612);
    check("pclr_cpu_ack_while_busy", 64'(ack_busy), 64'd0);
    @(negedge clk);
    check("pclr_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check("pclr_cpu_rdata", 64'(cpu_rdata), 64'h0000);
    next_cycle();

    // Asynchronous reset in the middle of a clear.
    start_clear();
    for (int i = 0; i < 20; i++) next_cycle();
    #2;
    res = 1'b0;
    #1;
    check("rst_mid_clear_busy", 64'(clr_busy), 64'd0);
    check("rst_mid_clear_outs", all_outs(), 64'd0);
    @(negedge clk);
    #1;
    res = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("rst_abort_%0d", i), 64'({clr_busy, clr_done, ram_we}), 64'd0);
    end
    next_cycle();
`else
    // Without the clear engine, clr_req does nothing.
    beam_outside = 1'b1;
    clr_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("noclr_%0d", i), 64'({clr_busy, clr_done, ram_we}), 64'd0);
      next_cycle();
      clr_req = 1'b0;
    end
`endif

    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
